// File: rtl/spi_host_pkg.sv
// spi_host_pkg: shared FSM state encoding and byte width for the SPI host transmitter.
package spi_host_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        NEXT,
        HOLD
    } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: mode-0 sclk divider; toggles sclk every CLK_DIV enabled cycles and flags the edge about to happen.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sclk,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [7:0] div_cnt;
    logic       wrap;

    assign wrap       = enable && (div_cnt == 8'(CLK_DIV - 1));
    assign rise_pulse = wrap && !sclk;
    assign fall_pulse = wrap && sclk;

    // Half-period counter; sclk parks low whenever the shifter is not running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
            sclk    <= sclk ^ wrap;
        end
    end

endmodule

// File: rtl/spi_host_tx.sv
// spi_host_tx: SPI mode-0 host that streams framed bytes out on mosi; miso capture is built only with SPI_HOST_RX_EN.
module spi_host_tx
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [BYTE_BITS-1:0] tx_data,
    input  logic                 tx_last,
    output logic                 tx_ready,
    output logic                 rx_valid,
    output logic [BYTE_BITS-1:0] rx_data,
    output logic                 busy,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 ss,
    input  logic                 miso
);

    state_t               state;
    logic [BYTE_BITS-1:0] sh;
    logic                 last;
    logic [7:0]           cnt;
    logic [2:0]           bit_cnt;
    logic                 rise;
    logic                 fall;
    logic                 done;
    logic                 accept;

    // A frame ending in NEXT must not swallow a byte it would then drop in HOLD.
    assign tx_ready = (state == IDLE) || (state == NEXT && !last);
    assign accept   = tx_valid && tx_ready;
    assign busy     = state != IDLE;
    assign mosi     = sh[BYTE_BITS-1];
    // The 8th fall follows the rise that wrapped the bit counter back to 0.
    assign done     = fall && (bit_cnt == 3'd0);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .enable     (state == SHIFT),
        .sclk       (sclk),
        .rise_pulse (rise),
        .fall_pulse (fall)
    );

    // Frame sequencer: slave select, shift register, lead/hold timing and bit count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ss      <= 1'b1;
            sh      <= '0;
            last    <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sh    <= tx_data;
                    last  <= tx_last;
                    ss    <= 1'b0;
                    state <= LEAD;
                end
                LEAD: begin
                    cnt   <= (cnt == 8'(CLK_DIV - 1)) ? 8'd0 : cnt + 8'd1;
                    state <= (cnt == 8'(CLK_DIV - 1)) ? SHIFT : LEAD;
                end
                SHIFT: begin
                    if (rise) bit_cnt <= bit_cnt + 3'd1;
                    if (fall) sh <= {sh[BYTE_BITS-2:0], 1'b0};
                    if (done) begin
                        ss    <= last;
                        state <= NEXT;
                    end
                end
                NEXT: if (last) begin
                    state <= HOLD;
                end else if (accept) begin
                    sh    <= tx_data;
                    last  <= tx_last;
                    state <= SHIFT;
                end
                HOLD: begin
                    cnt   <= (cnt == 8'(SS_GAP - 1)) ? 8'd0 : cnt + 8'd1;
                    state <= (cnt == 8'(SS_GAP - 1)) ? IDLE : HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_HOST_RX_EN
    logic [BYTE_BITS-1:0] rx_sh;

    // miso is sampled on every sclk rise and the byte is published as sclk returns low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= done;
            if (rise) rx_sh <= {rx_sh[BYTE_BITS-2:0], miso};
            if (done) rx_data <= rx_sh;
        end
    end
`else
    logic unused_miso;

    assign unused_miso = miso;
    assign rx_valid    = 1'b0;
    assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_host_tx.sv
// tb_spi_host_tx: randomized scenario bench for spi_host_tx, checked against waveform-level expectations.
module tb_spi_host_tx;

    localparam int D   = 2;
    localparam int GAP = 2;
`ifdef SPI_HOST_RX_EN
    localparam bit RX = 1'b1;
`else
    localparam bit RX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso;
    logic       tx_ready, rx_valid, busy, sclk, mosi, ss;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_bytes[8];
    logic [7:0] miso_bytes[8];
    bit         loop_mode = 1'b0;
    int         r_base = 0;
    logic [7:0] exp_rx_data = 8'h00;

    int   r = 0;
    int   ss_low = 0;
    int   sclk_bad = 0;
    logic prev_sclk = 1'b0;
    logic prev_ss = 1'b1;
    logic mosi_q[$];
    logic [7:0] rx_q[$];

    spi_host_tx #(.CLK_DIV(D), .SS_GAP(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss       (ss),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    // Slave model: idles high when deselected, otherwise loops mosi back or shifts out the scripted byte MSB first.
    always_comb begin
        miso = ss ? 1'b1 : loop_mode ? mosi : miso_bytes[((r - r_base) / 8) % 8][7 - ((r - r_base) % 8)];
    end

    // Bus monitor sampled mid-cycle: records mosi at each sclk rise, ss-low time, rx pulses and illegal sclk motion.
    always @(negedge clk) begin
        if (sclk && !prev_sclk) begin
            mosi_q.push_back(mosi);
            r++;
        end
        if (sclk !== prev_sclk && ss && prev_ss) sclk_bad++;
        if (!ss) ss_low++;
        if (rx_valid) rx_q.push_back(rx_data);
        prev_sclk = sclk;
        prev_ss   = ss;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic send(input logic [7:0] d, input logic l, output bit ok);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = tx_ready;
        if (ok) begin
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = !busy;
    endtask

    task automatic run_frame(input string name, input int n, input bit lp);
        int mb, rb, sl, c;
        bit ok;
        logic [7:0] got;
        logic [7:0] want;
        loop_mode = lp;
        r_base    = r;
        mb        = mosi_q.size();
        rb        = rx_q.size();
        sl        = ss_low;
        for (int i = 0; i < n; i++) begin
            send(tx_bytes[i], i == n - 1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s send%0d: tx_ready stayed 0", name, i);
            end
            if (i == 0) begin
                c = 0;
                while (!sclk && c < 1000) begin
                    @(posedge clk); #1;
                    c++;
                end
                checks++;
                if (c !== 2 * D) begin
                    errors++;
                    $display("FAIL %s first_rise: %0d cycles after accept, expected %0d", name, c, 2 * D);
                end
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s idle: busy stuck at 1", name);
        end
        @(posedge clk); #1;
        checks++;
        if (r - r_base !== 8 * n) begin
            errors++;
            $display("FAIL %s rises: got %0d expected %0d", name, r - r_base, 8 * n);
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) got[7-k] = (mb + 8 * i + k < mosi_q.size()) ? mosi_q[mb + 8 * i + k] : 1'bx;
            checks++;
            if (got !== tx_bytes[i]) begin
                errors++;
                $display("FAIL %s mosi_byte%0d: got %h expected %h", name, i, got, tx_bytes[i]);
            end
        end
        checks++;
        if (ss_low - sl !== D + 16 * D * n + (n - 1)) begin
            errors++;
            $display("FAIL %s ss_low: got %0d cycles expected %0d", name, ss_low - sl, D + 16 * D * n + (n - 1));
        end
        checks++;
        if (rx_q.size() - rb !== (RX ? n : 0)) begin
            errors++;
            $display("FAIL %s rx_count: got %0d expected %0d", name, rx_q.size() - rb, RX ? n : 0);
        end
        for (int i = 0; i < rx_q.size() - rb && i < n; i++) begin
            want = lp ? tx_bytes[i] : miso_bytes[i];
            checks++;
            if (rx_q[rb + i] !== want) begin
                errors++;
                $display("FAIL %s rx_byte%0d: got %h expected %h", name, i, rx_q[rb + i], want);
            end
        end
        exp_rx_data = RX ? (lp ? tx_bytes[n-1] : miso_bytes[n-1]) : 8'h00;
        checks++;
        if (rx_data !== exp_rx_data) begin
            errors++;
            $display("FAIL %s rx_data: got %h expected %h", name, rx_data, exp_rx_data);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ss, sclk, mosi, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_pins: ss/sclk/mosi/busy got %b expected 1000", {ss, sclk, mosi, busy});
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", tx_ready);
        end
        checks++;
        if ({rx_valid, rx_data} !== 9'h000) begin
            errors++;
            $display("FAIL reset_rx: rx_valid %b rx_data %h expected 0/00", rx_valid, rx_data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_loopback();
        tx_bytes[0] = 8'hA5;
        run_frame("loopback_a5", 1, 1'b1);
    endtask

    task automatic test_two_byte();
        tx_bytes[0]   = 8'h1B;
        tx_bytes[1]   = 8'h80;
        miso_bytes[0] = 8'h3C;
        miso_bytes[1] = 8'hFF;
        run_frame("two_byte", 2, 1'b0);
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 5; f++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                tx_bytes[i]   = 8'($urandom);
                miso_bytes[i] = 8'($urandom);
            end
            run_frame($sformatf("random%0d", f), n, 1'($urandom));
        end
    endtask

    task automatic test_stall();
        int mb, rb, c, bad;
        bit ok;
        logic [7:0] got;
        tx_bytes[0]   = 8'($urandom);
        tx_bytes[1]   = 8'($urandom);
        miso_bytes[0] = 8'($urandom);
        miso_bytes[1] = 8'($urandom);
        loop_mode = 1'b0;
        r_base    = r;
        mb        = mosi_q.size();
        rb        = rx_q.size();
        send(tx_bytes[0], 1'b0, ok);
        c = 0;
        while (!(busy && tx_ready) && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if ((busy && tx_ready) !== 1'b1 || !ok) begin
            errors++;
            $display("FAIL stall_wait: busy %b tx_ready %b, expected 1/1 between bytes", busy, tx_ready);
        end
        bad = 0;
        for (int s = 0; s < 50; s++) begin
            @(posedge clk); #1;
            if ({ss, sclk, busy} !== 3'b001) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: %0d of 50 cycles had ss/sclk/busy != 001", bad);
        end
        send(tx_bytes[1], 1'b1, ok);
        c = 0;
        while (!sclk && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (c !== D) begin
            errors++;
            $display("FAIL stall_no_lead: first rise %0d cycles after accept, expected %0d", c, D);
        end
        wait_idle(ok);
        @(posedge clk); #1;
        checks++;
        if (r - r_base !== 16) begin
            errors++;
            $display("FAIL stall_rises: got %0d expected 16", r - r_base);
        end
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) got[7-k] = (mb + 8 * i + k < mosi_q.size()) ? mosi_q[mb + 8 * i + k] : 1'bx;
            checks++;
            if (got !== tx_bytes[i]) begin
                errors++;
                $display("FAIL stall_mosi%0d: got %h expected %h", i, got, tx_bytes[i]);
            end
        end
        checks++;
        if (rx_q.size() - rb !== (RX ? 2 : 0)) begin
            errors++;
            $display("FAIL stall_rx_count: got %0d expected %0d", rx_q.size() - rb, RX ? 2 : 0);
        end
        for (int i = 0; i < rx_q.size() - rb && i < 2; i++) begin
            checks++;
            if (rx_q[rb + i] !== miso_bytes[i]) begin
                errors++;
                $display("FAIL stall_rx%0d: got %h expected %h", i, rx_q[rb + i], miso_bytes[i]);
            end
        end
        exp_rx_data = RX ? miso_bytes[1] : 8'h00;
    endtask

    task automatic test_reset_mid();
        int rb, c;
        bit ok;
        loop_mode = 1'b1;
        r_base    = r;
        rb        = rx_q.size();
        send(8'($urandom), 1'b1, ok);
        c = 0;
        while (r - r_base < 3 && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (r - r_base !== 3) begin
            errors++;
            $display("FAIL rstmid_rises: got %0d expected 3 before reset", r - r_base);
        end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ss, sclk, mosi, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid_async: ss/sclk/mosi/busy got %b expected 1000", {ss, sclk, mosi, busy});
        end
        checks++;
        if ({rx_valid, rx_data} !== 9'h000) begin
            errors++;
            $display("FAIL rstmid_rx: rx_valid %b rx_data %h expected 0/00", rx_valid, rx_data);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rx_q.size() !== rb) begin
            errors++;
            $display("FAIL rstmid_no_rx: %0d rx_valid pulses, expected 0", rx_q.size() - rb);
        end
        tx_bytes[0] = 8'h55;
        run_frame("after_reset_55", 1, 1'b1);
    endtask

    task automatic test_hold();
        int mb, c, hi;
        bit ok, acc;
        logic [7:0] got;
        tx_bytes[0] = 8'($urandom);
        tx_bytes[1] = 8'($urandom);
        loop_mode = 1'b1;
        r_base    = r;
        mb        = mosi_q.size();
        send(tx_bytes[0], 1'b1, ok);
        tx_valid = 1'b1;
        tx_data  = tx_bytes[1];
        tx_last  = 1'b1;
        acc = 1'b0;
        hi  = 0;
        c   = 0;
        while (!acc && c < 2000) begin
            if (tx_ready) begin
                acc = 1'b1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_ready: tx_ready seen with busy %b, expected busy 0", busy);
                end
                checks++;
                if (hi < GAP) begin
                    errors++;
                    $display("FAIL hold_gap: ss high %0d cycles before accept, expected >= %0d", hi, GAP);
                end
            end
            @(posedge clk); #1;
            c++;
            if (ss && !acc) hi++;
        end
        tx_valid = 1'b0;
        checks++;
        if (!acc || !ok) begin
            errors++;
            $display("FAIL hold_accept: second byte accepted %b, expected 1", acc);
        end
        wait_idle(ok);
        @(posedge clk); #1;
        checks++;
        if (r - r_base !== 16) begin
            errors++;
            $display("FAIL hold_rises: got %0d expected 16", r - r_base);
        end
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) got[7-k] = (mb + 8 * i + k < mosi_q.size()) ? mosi_q[mb + 8 * i + k] : 1'bx;
            checks++;
            if (got !== tx_bytes[i]) begin
                errors++;
                $display("FAIL hold_mosi%0d: got %h expected %h", i, got, tx_bytes[i]);
            end
        end
        exp_rx_data = RX ? tx_bytes[1] : 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tx_bytes[i]   = 8'h00;
            miso_bytes[i] = 8'hFF;
        end
        test_reset();
        test_loopback();
        test_two_byte();
        test_stall();
        test_reset_mid();
        test_hold();
        test_random();
        checks++;
        if (sclk_bad !== 0) begin
            errors++;
            $display("FAIL sclk_while_deselected: %0d toggles, expected 0", sclk_bad);
        end
        checks++;
        if (rx_data !== exp_rx_data) begin
            errors++;
            $display("FAIL final_rx_data: got %h expected %h", rx_data, exp_rx_data);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_host_tx.md
SPI_HOST_TX -- requirements
Module: spi_host_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sclk half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter SS_GAP, default 2: minimum clk cycles ss stays high between frames, legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_valid  input  1  tx_data/tx_last are valid.
REQ-006 SHALL have port tx_data  input  8  byte to transmit, sent MSB first.
REQ-007 SHALL have port tx_last  input  1  the byte is the final byte of the frame.
REQ-008 SHALL have port tx_ready  output  1  the block accepts a byte this cycle.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data holds the byte captured from miso.
REQ-010 SHALL have port rx_data  output  8  captured miso byte.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port sclk  output  1  SPI clock, mode 0 (idle low).
REQ-013 SHALL have port mosi  output  1  serial data to the neuron grid.
REQ-014 SHALL have port ss  output  1  active-low slave select.
REQ-015 SHALL have port miso  input  1  serial data from the grid; reads 0xFF when the grid is deselected.

Function
REQ-016 SHALL implement FSM IDLE -> LEAD -> SHIFT -> NEXT -> (SHIFT | HOLD) -> IDLE.
REQ-017 A byte SHALL be accepted only when tx_valid && tx_ready; tx_ready SHALL be 1 only in IDLE and NEXT.
REQ-018 IDLE acceptance SHALL load the shift register, drive ss low on the next cycle, and enter LEAD.
REQ-019 LEAD SHALL last one half-period (CLK_DIV cycles), with sclk low and mosi = bit 7.
REQ-020 SHIFT SHALL run 8 sclk periods; a divider counter 0..CLK_DIV-1 SHALL toggle sclk on wrap.
REQ-021 On each sclk rise, miso SHALL be sampled into the rx shift register.
REQ-022 On each sclk fall, mosi SHALL advance to the next lower bit; a 3-bit counter SHALL wrap 7->0 after the 8th rise.
REQ-023 One byte SHALL take exactly 16*CLK_DIV clk cycles from LEAD/NEXT exit to NEXT entry.
REQ-024 On NEXT entry, rx_valid SHALL pulse for one cycle and rx_data SHALL update.
REQ-025 In NEXT, if the previous byte carried tx_last, the FSM SHALL go to HOLD with ss high; else it SHALL wait with ss low and sclk low until a byte is accepted, then enter SHIFT (no LEAD).
REQ-026 HOLD SHALL keep ss high for SS_GAP cycles, then enter IDLE; tx_valid SHALL be ignored in HOLD.
REQ-027 tx_last SHALL be latched at acceptance; changes to tx_data or tx_last after acceptance SHALL have no effect.
REQ-028 sclk SHALL never toggle while ss is high.

Reset
REQ-029 While rst=0: ss=1, sclk=0, mosi=0, busy=0, rx_valid=0, rx_data=0x00, tx_ready=1, FSM=IDLE, all counters 0.
REQ-030 Reset asserted mid-frame SHALL force ss high immediately (asynchronously), discard the partial byte, and emit no rx_valid.

Configuration
REQ-031 With macro SPI_HOST_RX_EN defined, miso capture and rx_valid/rx_data SHALL operate per REQ-021/024.
REQ-032 Without SPI_HOST_RX_EN, the rx shift register SHALL be absent, rx_valid tied 0, rx_data tied 0x00, and miso unused; TX timing SHALL be unchanged.

Structure
REQ-033 A shared package spi_host_pkg SHALL hold the FSM state enum (IDLE, LEAD, SHIFT, NEXT, HOLD) and the constant BYTE_BITS=8.
REQ-034 The sclk divider/edge generator SHALL be the single sub-module spi_clk_gen, with inputs enable and CLK_DIV and outputs sclk, rise_pulse and fall_pulse.

Verification
REQ-035 CLK_DIV=2; send 0xA5 with tx_last=1, miso looped to mosi -> mosi at rises = 1,0,1,0,0,1,0,1; ss low for 2+32 cycles; rx_data=0xA5 pulsed once; ss high for at least 2 cycles afterwards.
REQ-036 Frame 0x1B, 0x80(last), miso driven by a model returning 0x3C, 0xFF -> ss stays low between bytes; 16 sclk rises; rx_data = 0x3C then 0xFF.
REQ-037 First byte non-last, tx_valid held low 50 cycles -> ss low, sclk low, busy=1 throughout the stall; the next byte then resumes with no LEAD.
REQ-038 rst=0 pulse after the 3rd sclk rise -> ss=1 and sclk=0 in the same cycle, no rx_valid; next frame 0x55 transmits correctly.
REQ-039 tx_valid held high during HOLD -> tx_ready=0 and no acceptance until IDLE.
REQ-040 Build without SPI_HOST_RX_EN, repeat REQ-035 -> identical mosi/ss/sclk waveform; rx_valid never 1.
